// File: rtl/mram_serial_host.sv
// Host-side initiator for the MRAM serial link: accepts parallel read/write commands,
// shifts address/write data out LSB first and reassembles the returned read word.
module mram_serial_host #(
  parameter int ADDR_W     = 20,
  parameter int DATA_W     = 16,
  parameter int RD_LATENCY = 2,
  parameter int GAP_CYCLES = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic              cmd_write,
  input  logic [ADDR_W-1:0] cmd_addr,
  input  logic [DATA_W-1:0] cmd_wdata,
  output logic              done,
  output logic              done_write,
  output logic [DATA_W-1:0] rd_data,
  output logic              addr_in,
  output logic              data_in,
  output logic              read_write_sel,
  output logic              frame_active,
  input  logic              ser_data_out,
  output logic              busy
);

  localparam int CW = $clog2(ADDR_W + 1);
  localparam logic [CW-1:0] SHIFT_LD = CW'(ADDR_W - 1);
  localparam logic [CW-1:0] WAIT_LD  = CW'((RD_LATENCY > 0) ? RD_LATENCY - 1 : 0);
  localparam logic [CW-1:0] CAP_LD   = CW'(DATA_W - 1);
  localparam logic [CW-1:0] GAP_LD   = CW'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);

  typedef enum logic [2:0] {
    S_IDLE, S_SETUP, S_SHIFT, S_WAIT, S_CAPTURE, S_DONE, S_GAP
  } state_t;

  state_t              state, state_n;
  logic [CW-1:0]       cnt, cnt_n;
  logic                wr_q, wr_n;
  logic [ADDR_W-1:0]   addr_sh, addr_sh_n;
  logic [DATA_W-1:0]   wdata_sh, wdata_sh_n;
  logic [DATA_W-2:0]   rd_shift, rd_shift_n;
  logic [DATA_W-1:0]   rd_data_n;
  logic                addr_in_n, data_in_n, rws_n, frame_active_n;
  logic                done_n, done_write_n, busy_n, cmd_ready_n;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state          <= S_IDLE;
      cnt            <= '0;
      wr_q           <= 1'b0;
      addr_sh        <= '0;
      wdata_sh       <= '0;
      rd_shift       <= '0;
      rd_data        <= '0;
      addr_in        <= 1'b0;
      data_in        <= 1'b0;
      read_write_sel <= 1'b0;
      frame_active   <= 1'b0;
      done           <= 1'b0;
      done_write     <= 1'b0;
      busy           <= 1'b0;
      cmd_ready      <= 1'b1;
    end else begin
      state          <= state_n;
      cnt            <= cnt_n;
      wr_q           <= wr_n;
      addr_sh        <= addr_sh_n;
      wdata_sh       <= wdata_sh_n;
      rd_shift       <= rd_shift_n;
      rd_data        <= rd_data_n;
      addr_in        <= addr_in_n;
      data_in        <= data_in_n;
      read_write_sel <= rws_n;
      frame_active   <= frame_active_n;
      done           <= done_n;
      done_write     <= done_write_n;
      busy           <= busy_n;
      cmd_ready      <= cmd_ready_n;
    end
  end

  // Next state plus next value of every output, so the ports are pure flops.
  always_comb begin
    state_n    = state;
    cnt_n      = (cnt != '0) ? cnt - CW'(1) : cnt;
    wr_n       = wr_q;
    addr_sh_n  = addr_sh;
    wdata_sh_n = wdata_sh;
    rd_shift_n = rd_shift;
    rd_data_n  = rd_data;
    addr_in_n  = 1'b0;
    data_in_n  = 1'b0;

    case (state)
      S_IDLE: begin
        if (cmd_valid) begin
          state_n    = S_SETUP;
          wr_n       = cmd_write;
          addr_sh_n  = cmd_addr;
          wdata_sh_n = cmd_wdata;
        end
      end
      S_SETUP: begin
        state_n = S_SHIFT;
        cnt_n   = SHIFT_LD;
      end
      S_SHIFT: begin
        if (cnt == '0) begin
          if (wr_q) begin
            state_n = S_DONE;
          end else if (RD_LATENCY == 0) begin
            state_n = S_CAPTURE;
            cnt_n   = CAP_LD;
          end else begin
            state_n = S_WAIT;
            cnt_n   = WAIT_LD;
          end
        end
      end
      S_WAIT: begin
        if (cnt == '0) begin
          state_n = S_CAPTURE;
          cnt_n   = CAP_LD;
        end
      end
      S_CAPTURE: begin
        // Bits enter at the top and walk down, so the first one ends at bit 0.
        rd_shift_n = {ser_data_out, rd_shift[DATA_W-2:1]};
        if (cnt == '0) begin
          rd_data_n = {ser_data_out, rd_shift};
          state_n   = S_DONE;
        end
      end
      S_DONE: begin
        if (GAP_CYCLES == 0) begin
          state_n = S_IDLE;
        end else begin
          state_n = S_GAP;
          cnt_n   = GAP_LD;
        end
      end
      S_GAP: begin
        if (cnt == '0) state_n = S_IDLE;
      end
      default: state_n = S_IDLE;
    endcase

    if (state_n == S_SHIFT) begin
      addr_in_n  = addr_sh[0];
      data_in_n  = wr_q & wdata_sh[0];
      addr_sh_n  = {1'b0, addr_sh[ADDR_W-1:1]};
      wdata_sh_n = {1'b0, wdata_sh[DATA_W-1:1]};
    end

    rws_n          = (state_n != S_IDLE) && wr_n;
    frame_active_n = (state_n == S_SETUP) || (state_n == S_SHIFT);
    done_n         = (state_n == S_DONE);
    done_write_n   = (state_n == S_DONE) && wr_q;
    busy_n         = (state_n != S_IDLE);
    cmd_ready_n    = (state_n == S_IDLE);
  end

endmodule
